// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Predicts next fetch PC combinationally and trains from resolved Execute-stage branches.
module branch_target_predictor #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned INDEX_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PCF,
   output logic                  PredTakenF,
   output logic [DATA_WIDTH-1:0] PredTargetF,
   input  logic                  UpdateE,
   input  logic [DATA_WIDTH-1:0] PCE,
   input  logic                  ActualTakenE,
   input  logic [DATA_WIDTH-1:0] ActualTargetE,
   input  logic                  PredTakenE,
   input  logic [DATA_WIDTH-1:0] PredTargetE,
   output logic                  MispredictE,
   output logic [DATA_WIDTH-1:0] RecoverPCE,
   output logic [31:0]           BranchCount,
   output logic [31:0]           MispredictCount
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam int unsigned TAG_W   = DATA_WIDTH - INDEX_BITS - 2;
   localparam int unsigned CNT_W   = 32;

   localparam logic [1:0] CTR_RESET = 2'b01;
   localparam logic [1:0] CTR_ALLOC = 2'b10;
   localparam logic [1:0] CTR_MAX   = 2'b11;
   localparam logic [1:0] CTR_MIN   = 2'b00;

   logic [ENTRIES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [TAG_W-1:0]      tag_d    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_q [ENTRIES];
   logic [DATA_WIDTH-1:0] target_d [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];
   logic [1:0]            ctr_d    [ENTRIES];
   logic [CNT_W-1:0]      branch_count_q, branch_count_d;
   logic [CNT_W-1:0]      mispredict_count_q, mispredict_count_d;

   logic [INDEX_BITS-1:0] idx_f, idx_e;
   logic [TAG_W-1:0]      tag_f, tag_e;
   logic                  hit_f, hit_e;
   logic                  mispredict;

   // Fetch-side lookup sees only registered state, so same-cycle training is not bypassed
   always_comb begin
      idx_f       = PCF[INDEX_BITS+1:2];
      tag_f       = PCF[DATA_WIDTH-1:INDEX_BITS+2];
      hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
      PredTakenF  = hit_f && ctr_q[idx_f][1];
      PredTargetF = PredTakenF ? target_q[idx_f] : PCF + DATA_WIDTH'(4);
   end

   // Execute-side resolution and recovery address
   always_comb begin
      idx_e       = PCE[INDEX_BITS+1:2];
      tag_e       = PCE[DATA_WIDTH-1:INDEX_BITS+2];
      hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
      mispredict  = UpdateE && ((PredTakenE != ActualTakenE) ||
                                (ActualTakenE && (PredTargetE != ActualTargetE)));
      MispredictE = mispredict;
      RecoverPCE  = ActualTakenE ? ActualTargetE : PCE + DATA_WIDTH'(4);
   end

   // Training: hits move the counter, taken misses allocate weakly-taken entries
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (UpdateE) begin
         if (hit_e) begin
            if (ActualTakenE) begin
               target_d[idx_e] = ActualTargetE;
               if (ctr_q[idx_e] != CTR_MAX) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
            end else if (ctr_q[idx_e] != CTR_MIN) begin
               ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
            end
         end else if (ActualTakenE) begin
            valid_d[idx_e]  = 1'b1;
            tag_d[idx_e]    = tag_e;
            target_d[idx_e] = ActualTargetE;
            ctr_d[idx_e]    = CTR_ALLOC;
         end
      end
   end

   always_comb begin
      branch_count_d     = branch_count_q + CNT_W'(UpdateE);
      mispredict_count_d = mispredict_count_q + CNT_W'(mispredict);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q            <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_RESET;
         end
      end else begin
         valid_q            <= valid_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

   assign BranchCount     = branch_count_q;
   assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios plus a
// randomized run against a table-of-entries reference model.
module tb_branch_target_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        UpdateE;
   logic [31:0] PCE;
   logic        ActualTakenE;
   logic [31:0] ActualTargetE;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        MispredictE;
   logic [31:0] RecoverPCE;
   logic [31:0] BranchCount;
   logic [31:0] MispredictCount;

   int checks   = 0;
   int failures = 0;

   // Reference model: one record per table slot, counter kept as an integer 0..3
   bit          m_v   [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_ctr [16];
   logic [31:0] m_bc;
   logic [31:0] m_mc;

   branch_target_predictor #(.DATA_WIDTH(32), .INDEX_BITS(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .PCF            (PCF),
      .PredTakenF     (PredTakenF),
      .PredTargetF    (PredTargetF),
      .UpdateE        (UpdateE),
      .PCE            (PCE),
      .ActualTakenE   (ActualTakenE),
      .ActualTargetE  (ActualTargetE),
      .PredTakenE     (PredTakenE),
      .PredTargetE    (PredTargetE),
      .MispredictE    (MispredictE),
      .RecoverPCE     (RecoverPCE),
      .BranchCount    (BranchCount),
      .MispredictCount(MispredictCount)
   );

   always #5 clk = ~clk;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_v[slot(pc)] && (m_tag[slot(pc)] == (pc / 64));
   endfunction

   function automatic bit m_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_target(input logic [31:0] pc);
      return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
   endfunction

   function automatic bit m_mispred();
      return UpdateE && ((PredTakenE != ActualTakenE) ||
                         (ActualTakenE && (PredTargetE != ActualTargetE)));
   endfunction

   function automatic logic [31:0] m_recover();
      return ActualTakenE ? ActualTargetE : PCE + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_v[i]   = 1'b0;
         m_tag[i] = '0;
         m_tgt[i] = '0;
         m_ctr[i] = 1;
      end
      m_bc = '0;
      m_mc = '0;
   endtask

   task automatic model_train();
      int s;
      s = slot(PCE);
      if (m_hit(PCE)) begin
         if (ActualTakenE) begin
            m_tgt[s] = ActualTargetE;
            m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
         end else begin
            m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
         end
      end else if (ActualTakenE) begin
         m_v[s]   = 1'b1;
         m_tag[s] = PCE / 64;
         m_tgt[s] = ActualTargetE;
         m_ctr[s] = 2;
      end
   endtask

   // One clock: model follows the same edge the DUT sees, then settle away from the edge
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (UpdateE) begin
         m_bc = m_bc + 32'd1;
         if (m_mispred()) m_mc = m_mc + 32'd1;
         model_train();
      end
      #2;
   endtask

   task automatic drive_upd(input logic en, input logic [31:0] pce, input logic at,
                            input logic [31:0] atg, input logic pt, input logic [31:0] ptg);
      UpdateE       = en;
      PCE           = pce;
      ActualTakenE  = at;
      ActualTargetE = atg;
      PredTakenE    = pt;
      PredTargetE   = ptg;
      #1;
   endtask

   task automatic idle();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      PCF = 32'h40;
      idle();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (PredTakenF !== 1'b0) begin
         failures++;
         $display("FAIL reset_taken got=%0b exp=0", PredTakenF);
      end
      checks++;
      if (PredTargetF !== 32'h44) begin
         failures++;
         $display("FAIL reset_target got=%h exp=00000044", PredTargetF);
      end
      checks++;
      if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
         failures++;
         $display("FAIL reset_counts got=%0d/%0d exp=0/0", BranchCount, MispredictCount);
      end
   endtask

   task automatic test_first_train();
      PCF = 32'h40;
      drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
      checks++;
      if (MispredictE !== 1'b1 || RecoverPCE !== 32'h100) begin
         failures++;
         $display("FAIL first_mispredict got=%0b/%h exp=1/00000100", MispredictE, RecoverPCE);
      end
      tick();
      idle();
      checks++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h100) begin
         failures++;
         $display("FAIL first_predict got=%0b/%h exp=1/00000100", PredTakenF, PredTargetF);
      end
      checks++;
      if (BranchCount !== 32'd1 || MispredictCount !== 32'd1) begin
         failures++;
         $display("FAIL first_counts got=%0d/%0d exp=1/1", BranchCount, MispredictCount);
      end
   endtask

   task automatic test_saturation();
      bit exp_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      bit dir   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] exp_tg;
      PCF = 32'h40;
      for (int k = 0; k < 4; k++) begin
         drive_upd(1'b1, 32'h40, dir[k], 32'h100, m_taken(32'h40), m_target(32'h40));
         tick();
         idle();
         exp_tg = exp_t[k] ? 32'h100 : 32'h44;
         checks++;
         if (PredTakenF !== exp_t[k] || PredTargetF !== exp_tg) begin
            failures++;
            $display("FAIL saturation_step%0d got=%0b/%h exp=%0b/%h",
                     k, PredTakenF, PredTargetF, exp_t[k], exp_tg);
         end
      end
   endtask

   task automatic test_aliasing();
      PCF = 32'h80;
      idle();
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h84) begin
         failures++;
         $display("FAIL alias_miss got=%0b/%h exp=0/00000084", PredTakenF, PredTargetF);
      end
      drive_upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
      tick();
      idle();
      checks++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h200) begin
         failures++;
         $display("FAIL alias_alloc got=%0b/%h exp=1/00000200", PredTakenF, PredTargetF);
      end
      PCF = 32'h40;
      #1;
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h44) begin
         failures++;
         $display("FAIL alias_evict got=%0b/%h exp=0/00000044", PredTakenF, PredTargetF);
      end
   endtask

   task automatic test_notaken_and_target();
      PCF = 32'h300;
      drive_upd(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h304);
      checks++;
      if (MispredictE !== 1'b0 || RecoverPCE !== 32'h304) begin
         failures++;
         $display("FAIL nt_resolve got=%0b/%h exp=0/00000304", MispredictE, RecoverPCE);
      end
      tick();
      idle();
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h304) begin
         failures++;
         $display("FAIL nt_noalloc got=%0b/%h exp=0/00000304", PredTakenF, PredTargetF);
      end
      PCF = 32'h40;
      drive_upd(1'b1, 32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
      checks++;
      if (MispredictE !== 1'b1 || RecoverPCE !== 32'h180) begin
         failures++;
         $display("FAIL tgt_mispredict got=%0b/%h exp=1/00000180", MispredictE, RecoverPCE);
      end
      tick();
      idle();
      checks++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h180) begin
         failures++;
         $display("FAIL tgt_retrain got=%0b/%h exp=1/00000180", PredTakenF, PredTargetF);
      end
      checks++;
      if (BranchCount !== m_bc || MispredictCount !== m_mc) begin
         failures++;
         $display("FAIL dir_counts got=%0d/%0d exp=%0d/%0d", BranchCount, MispredictCount, m_bc, m_mc);
      end
   endtask

   task automatic test_reset_with_update();
      PCF = 32'h40;
      rst = 1'b1;
      drive_upd(1'b1, 32'h80, 1'b1, 32'h240, 1'b0, 32'h84);
      tick();
      rst = 1'b0;
      idle();
      for (int k = 0; k < 4; k++) begin
         PCF = (k == 0) ? 32'h40 : (k == 1) ? 32'h80 : (k == 2) ? 32'h300 : 32'hFFFF_FFFC;
         #1;
         checks++;
         if (PredTakenF !== 1'b0 || PredTargetF !== PCF + 32'd4) begin
            failures++;
            $display("FAIL rst_flush pc=%h got=%0b/%h exp=0/%h", PCF, PredTakenF, PredTargetF, PCF + 32'd4);
         end
      end
      checks++;
      if (BranchCount !== 32'd0 || MispredictCount !== 32'd0) begin
         failures++;
         $display("FAIL rst_counts got=%0d/%0d exp=0/0", BranchCount, MispredictCount);
      end
   endtask

   task automatic test_same_cycle();
      PCF = 32'h40;
      drive_upd(1'b1, 32'h40, 1'b1, 32'h140, 1'b0, 32'h44);
      checks++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h44) begin
         failures++;
         $display("FAIL same_cycle_old got=%0b/%h exp=0/00000044", PredTakenF, PredTargetF);
      end
      tick();
      idle();
      checks++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h140) begin
         failures++;
         $display("FAIL same_cycle_new got=%0b/%h exp=1/00000140", PredTakenF, PredTargetF);
      end
   endtask

   task automatic test_random();
      logic [31:0] pce;
      logic        faithful;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         PCF = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
         pce = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
         faithful = ($urandom_range(0, 3) != 0);
         drive_upd(1'($urandom_range(0, 1)), pce, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 7)) << 4,
                   faithful ? m_taken(pce) : 1'($urandom_range(0, 1)),
                   faithful ? m_target(pce) : 32'($urandom_range(0, 7)) << 4);
         checks++;
         if (PredTakenF !== m_taken(PCF) || PredTargetF !== m_target(PCF)) begin
            failures++;
            $display("FAIL rand_predict n=%0d pc=%h got=%0b/%h exp=%0b/%h",
                     n, PCF, PredTakenF, PredTargetF, m_taken(PCF), m_target(PCF));
         end
         checks++;
         if (MispredictE !== m_mispred() || (UpdateE && RecoverPCE !== m_recover())) begin
            failures++;
            $display("FAIL rand_resolve n=%0d got=%0b/%h exp=%0b/%h",
                     n, MispredictE, RecoverPCE, m_mispred(), m_recover());
         end
         tick();
         checks++;
         if (BranchCount !== m_bc || MispredictCount !== m_mc) begin
            failures++;
            $display("FAIL rand_counts n=%0d got=%0d/%0d exp=%0d/%0d",
                     n, BranchCount, MispredictCount, m_bc, m_mc);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      PCF = 32'h0;
      idle();
      model_reset();
      test_reset();
      test_first_train();
      test_saturation();
      test_aliasing();
      test_notaken_and_target();
      test_reset_with_update();
      test_same_cycle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
